ysyx_22050854_cache_rd_arb: RTL and testbench
=============================================

# ysyx_22050854_cache_rd_arb

Read-port arbiter between the I-cache and D-cache refill/uncached read interfaces and the single AXI4 read channel of the memory subsystem. Each cache side speaks the native cache-to-bus protocol (rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_last/ret_data). The block buffers one request per requester, grants round-robin, converts rd_type into an AXI burst, and steers returned beats to the owner. It sits between both caches and the AXI crossbar.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data beat width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ic_rd_req / dc_rd_req  in  1  single-cycle request pulse, sampled only when own rd_rdy=1
- ic_rd_type / dc_rd_type  in  3  000 byte, 001 half, 010 word, 011 dword, 100 cache line (16B)
- ic_rd_addr / dc_rd_addr  in  ADDR_W  request address
- ic_rd_rdy / dc_rd_rdy  out  1  request buffer for that side empty
- ic_ret_valid / dc_ret_valid  out  1  returned beat valid for that side
- ic_ret_last / dc_ret_last  out  1  final beat of that side's transfer
- ic_ret_data / dc_ret_data  out  DATA_W  returned beat
- arvalid  out 1; arready  in 1; araddr  out ADDR_W; arlen  out 8; arsize  out 3; arburst  out 2
- rvalid  in 1; rready  out 1; rdata  in DATA_W; rlast  in 1; rresp  in 2
- rd_err  out  1  one-cycle pulse on a beat with rresp!=00

## Operation
- Per-side buffer {valid, type, addr}; loaded when rd_req=1 and rd_rdy=1; rd_rdy = ~valid; cleared on the clock edge accepting that side's rlast beat.
- Both sides may load in the same cycle; both are held.
- Grant register owner (IC/DC); last_grant reset to IC, so first tie goes to DC. Tie: grant side != last_grant; single pending: grant it. last_grant updated at grant.
- FSM IDLE -> AR -> R -> IDLE.
  - IDLE: if any buffer valid, latch owner and AXI fields, go AR. Else stay.
  - AR: arvalid=1, fields stable; on arvalid&arready go R.
  - R: rready=1; each rvalid beat forwarded to owner; on rvalid&rlast clear owner buffer, go IDLE.
- Type mapping: 000/001/010/011 -> arlen=0, arsize=type[1:0], araddr=rd_addr unchanged. 100 -> arlen=1, arsize=3, araddr={rd_addr[31:4],4'b0}. 101-111 -> treated as 011. arburst=01 (INCR) always.
- Return: owner_ret_valid = (state==R)&rvalid; ret_last = rlast; ret_data = rdata (combinational). Non-owner ret_valid/ret_last = 0, ret_data = 0. First line beat = bytes [7:0] of the line, second = [15:8].
- rresp!=00: data still forwarded, rd_err pulses same cycle; transfer completes normally on rlast.
- rvalid outside R ignored (rready=0). A beat after rlast is not expected; if it occurs in IDLE/AR it is dropped.

## Timing
- Reset values: arvalid 0, rready 0, araddr/arlen/arsize 0, arburst 01, both rd_rdy 1, all ret_* 0, rd_err 0, state IDLE, buffers empty, last_grant IC.
- rd_req at cycle N -> buffer valid N+1 -> arvalid high N+2 (no prior traffic).
- arvalid held with constant fields until arready; no combinational path arready->arvalid.
- ret beat latency: 0 cycles from rvalid.
- After rlast at cycle M: state IDLE at M+1; next pending request arvalid at M+2.
- rd_rdy for a side deasserts N+1 after its accepted req, reasserts the cycle after its rlast beat.
- Reset asserted mid-transfer: all outputs return to reset values immediately (async); buffered requests and outstanding AXI transaction are discarded; downstream is reset by the same rst.

## Test plan
- IC line read 0x8000_0014 alone -> arvalid N+2, araddr 0x8000_0010, arlen 1, arsize 3; beats 0x1111, 0x2222 on ic_ret_data, ic_ret_last on second; dc_ret_valid stays 0.
- IC and DC req same cycle (DC word 0xA000_0004) -> DC granted first (arlen 0, arsize 2, araddr 0xA000_0004), IC line follows at rlast+2; both rd_rdy low until own completion.
- Three back-to-back ties -> grant order DC, IC, DC, IC, DC, IC.
- arready held low 5 cycles -> arvalid and fields stable all 5 cycles; single handshake.
- rresp=10 on first line beat -> rd_err one pulse, data forwarded, transfer completes, rd_rdy returns 1.
- rst low during R state -> arvalid/rready/ret_valid 0 same cycle, both rd_rdy 1; new IC req after release served normally.

Source files
------------

// File: rtl/ysyx_22050854_cache_rd_arb.sv
// Read-port arbiter: buffers one I-cache and one D-cache read request and grants them round-robin
// onto a single AXI4 read channel, then steers the returned beats back to the owning cache.
module ysyx_22050854_cache_rd_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_rd_req,
   input  logic [2:0]        ic_rd_type,
   input  logic [ADDR_W-1:0] ic_rd_addr,
   output logic              ic_rd_rdy,
   output logic              ic_ret_valid,
   output logic              ic_ret_last,
   output logic [DATA_W-1:0] ic_ret_data,
   input  logic              dc_rd_req,
   input  logic [2:0]        dc_rd_type,
   input  logic [ADDR_W-1:0] dc_rd_addr,
   output logic              dc_rd_rdy,
   output logic              dc_ret_valid,
   output logic              dc_ret_last,
   output logic [DATA_W-1:0] dc_ret_data,
   output logic              arvalid,
   input  logic              arready,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rlast,
   input  logic [1:0]        rresp,
   output logic              rd_err
);

   // state | meaning
   // IDLE  | no transaction in flight; pick a pending buffer
   // AR    | address phase held until arready
   // R     | data beats forwarded to owner until rlast
   typedef enum logic [1:0] {IDLE, AR, R} state_e;

   state_e            state_q, state_d;
   logic              ic_vld_q, ic_vld_d, dc_vld_q, dc_vld_d;
   logic [2:0]        ic_type_q, ic_type_d, dc_type_q, dc_type_d;
   logic [ADDR_W-1:0] ic_addr_q, ic_addr_d, dc_addr_q, dc_addr_d;
   logic              owner_q, owner_d;           // 0 = IC, 1 = DC
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [2:0]        arsize_q, arsize_d;

   logic              grant_dc;
   logic [2:0]        sel_type;
   logic [ADDR_W-1:0] sel_addr;
   logic              beat;

   // On a tie the side that was not granted last wins.
   assign grant_dc = dc_vld_q & (~ic_vld_q | ~last_grant_q);
   assign sel_type = grant_dc ? dc_type_q : ic_type_q;
   assign sel_addr = grant_dc ? dc_addr_q : ic_addr_q;

   always_comb begin
      state_d      = state_q;
      ic_vld_d     = ic_vld_q;
      ic_type_d    = ic_type_q;
      ic_addr_d    = ic_addr_q;
      dc_vld_d     = dc_vld_q;
      dc_type_d    = dc_type_q;
      dc_addr_d    = dc_addr_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arsize_d     = arsize_q;

      if (ic_rd_req && !ic_vld_q) begin
         ic_vld_d  = 1'b1;
         ic_type_d = ic_rd_type;
         ic_addr_d = ic_rd_addr;
      end
      if (dc_rd_req && !dc_vld_q) begin
         dc_vld_d  = 1'b1;
         dc_type_d = dc_rd_type;
         dc_addr_d = dc_rd_addr;
      end

      case (state_q)
         IDLE: begin
            if (ic_vld_q || dc_vld_q) begin
               owner_d      = grant_dc;
               last_grant_d = grant_dc;
               state_d      = AR;
               if (sel_type == 3'b100) begin
                  araddr_d = {sel_addr[ADDR_W-1:4], 4'b0};
                  arlen_d  = 8'd1;
                  arsize_d = 3'd3;
               end else if (sel_type[2]) begin
                  araddr_d = sel_addr;
                  arlen_d  = 8'd0;
                  arsize_d = 3'd3;
               end else begin
                  araddr_d = sel_addr;
                  arlen_d  = 8'd0;
                  arsize_d = {1'b0, sel_type[1:0]};
               end
            end
         end
         AR: begin
            if (arready) state_d = R;
         end
         R: begin
            if (rvalid && rlast) begin
               if (owner_q) dc_vld_d = 1'b0;
               else         ic_vld_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ic_vld_q     <= 1'b0;
         ic_type_q    <= 3'b0;
         ic_addr_q    <= '0;
         dc_vld_q     <= 1'b0;
         dc_type_q    <= 3'b0;
         dc_addr_q    <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b0;
         araddr_q     <= '0;
         arlen_q      <= 8'd0;
         arsize_q     <= 3'd0;
      end else begin
         state_q      <= state_d;
         ic_vld_q     <= ic_vld_d;
         ic_type_q    <= ic_type_d;
         ic_addr_q    <= ic_addr_d;
         dc_vld_q     <= dc_vld_d;
         dc_type_q    <= dc_type_d;
         dc_addr_q    <= dc_addr_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arsize_q     <= arsize_d;
      end
   end

   assign ic_rd_rdy = ~ic_vld_q;
   assign dc_rd_rdy = ~dc_vld_q;
   assign arvalid   = (state_q == AR);
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = arsize_q;
   assign arburst   = 2'b01;
   assign rready    = (state_q == R);

   assign beat         = rready & rvalid;
   assign ic_ret_valid = beat & ~owner_q;
   assign dc_ret_valid = beat & owner_q;
   assign ic_ret_last  = ic_ret_valid & rlast;
   assign dc_ret_last  = dc_ret_valid & rlast;
   assign ic_ret_data  = ic_ret_valid ? rdata : '0;
   assign dc_ret_data  = dc_ret_valid ? rdata : '0;
   assign rd_err       = beat & (rresp != 2'b00);

endmodule

// File: tb/tb_ysyx_22050854_cache_rd_arb.sv
// Bench for the cache read arbiter: directed scenarios plus random traffic, all checked against
// a transaction-level model of pending requests, round-robin grants and AXI burst mapping.
module tb_ysyx_22050854_cache_rd_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic        ic_rd_req, dc_rd_req;
   logic [2:0]  ic_rd_type, dc_rd_type;
   logic [31:0] ic_rd_addr, dc_rd_addr;
   logic        ic_rd_rdy, dc_rd_rdy;
   logic        ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
   logic [63:0] ic_ret_data, dc_ret_data;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready, rlast, rd_err;
   logic [63:0] rdata;
   logic [1:0]  rresp;

   always #5 clk = ~clk;

   ysyx_22050854_cache_rd_arb #(.ADDR_W(32), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
      .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
      .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
      .rresp(rresp), .rd_err(rd_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // model: phase 0 no transfer, 1 address phase, 2 data phase; side 0 = IC, 1 = DC
   int          m_phase;
   bit          m_vld[2];
   logic [2:0]  m_type[2];
   logic [31:0] m_addr[2];
   int          m_last;
   int          m_own;
   int          beats_left;
   logic [31:0] e_addr;
   logic [7:0]  e_len;
   logic [2:0]  e_size;
   int          grants[$];

   bit          s_req[2];
   logic [2:0]  s_type[2];
   logic [31:0] s_addr[2];
   bit          s_arready, s_rvalid;
   logic [63:0] s_rdata;
   logic [1:0]  s_rresp;

   function automatic void exp_fields(input logic [2:0] t, input logic [31:0] a,
                                      output logic [31:0] ea, output logic [7:0] el,
                                      output logic [2:0] es);
      if (t == 3'd4) begin
         ea = a & ~32'hF; el = 8'd1; es = 3'd3;
      end else if (t > 3'd4) begin
         ea = a; el = 8'd0; es = 3'd3;
      end else begin
         ea = a; el = 8'd0; es = t;
      end
   endfunction

   task automatic model_reset();
      m_phase = 0; m_vld[0] = 0; m_vld[1] = 0; m_last = 0; m_own = 0; beats_left = 0;
   endtask

   task automatic clear_stim();
      s_req[0] = 0; s_req[1] = 0; s_type[0] = 0; s_type[1] = 0; s_addr[0] = 0; s_addr[1] = 0;
      s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
   endtask

   // Called at a falling edge; checks the cycle, then advances the model across the next rising edge.
   task automatic tick();
      bit          ev;
      bit          ev_side;
      bit          nv[2];
      int          g;
      chk("ic_rd_rdy", ic_rd_rdy, !m_vld[0]);
      chk("dc_rd_rdy", dc_rd_rdy, !m_vld[1]);
      chk("arvalid", arvalid, m_phase == 1);
      chk("rready", rready, m_phase == 2);
      chk("arburst", arburst, 2'b01);
      if (m_phase == 1) begin
         chk("araddr", araddr, e_addr);
         chk("arlen", arlen, e_len);
         chk("arsize", arsize, e_size);
      end
      ic_rd_req = s_req[0]; ic_rd_type = s_type[0]; ic_rd_addr = s_addr[0];
      dc_rd_req = s_req[1]; dc_rd_type = s_type[1]; dc_rd_addr = s_addr[1];
      arready = s_arready; rvalid = s_rvalid; rdata = s_rdata; rresp = s_rresp;
      rlast = (m_phase == 2) ? (beats_left == 1) : 1'($urandom_range(0, 1));
      #1;
      ev = (m_phase == 2) && s_rvalid;
      ev_side = ev && (m_own == 0);
      chk("ic_ret_valid", ic_ret_valid, ev_side);
      chk("ic_ret_last", ic_ret_last, ev_side ? rlast : 1'b0);
      chk("ic_ret_data", ic_ret_data, ev_side ? s_rdata : 64'd0);
      ev_side = ev && (m_own == 1);
      chk("dc_ret_valid", dc_ret_valid, ev_side);
      chk("dc_ret_last", dc_ret_last, ev_side ? rlast : 1'b0);
      chk("dc_ret_data", dc_ret_data, ev_side ? s_rdata : 64'd0);
      chk("rd_err", rd_err, ev && (s_rresp != 2'b00));

      nv[0] = m_vld[0]; nv[1] = m_vld[1];
      if (m_phase == 0) begin
         if (m_vld[0] || m_vld[1]) begin
            if (m_vld[0] && m_vld[1]) g = (m_last == 0) ? 1 : 0;
            else                      g = m_vld[1] ? 1 : 0;
            m_last = g; m_own = g; grants.push_back(g);
            exp_fields(m_type[g], m_addr[g], e_addr, e_len, e_size);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (s_arready) begin
            m_phase = 2; beats_left = int'(e_len) + 1;
         end
      end else begin
         if (s_rvalid) begin
            beats_left--;
            if (rlast) begin
               nv[m_own] = 0; m_phase = 0;
            end
         end
      end
      for (int s = 0; s < 2; s++) begin
         if (s_req[s] && !m_vld[s]) begin
            nv[s] = 1; m_type[s] = s_type[s]; m_addr[s] = s_addr[s];
         end
      end
      m_vld[0] = nv[0]; m_vld[1] = nv[1];
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      bit done = 0;
      s_req[0] = 0; s_req[1] = 0;
      for (int i = 0; i < 200; i++) begin
         if (m_phase == 0 && !m_vld[0] && !m_vld[1]) begin
            done = 1;
            break;
         end
         s_arready = 1; s_rvalid = 1; s_rdata = {$urandom, $urandom}; s_rresp = 0;
         tick();
      end
      s_arready = 0; s_rvalid = 0;
      chk(tag, done, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_stim();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      ic_rd_req = 0; dc_rd_req = 0; ic_rd_type = 0; dc_rd_type = 0; ic_rd_addr = 0; dc_rd_addr = 0;
      arready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
      clear_stim();
      model_reset();
      #1;
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_arlen", arlen, 8'd0);
      chk("rst_arsize", arsize, 3'd0);
      chk("rst_arburst", arburst, 2'b01);
      chk("rst_rready", rready, 1'b0);
      chk("rst_rdy", {ic_rd_rdy, dc_rd_rdy}, 2'b11);
      chk("rst_err", rd_err, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // IC line read alone: arvalid two cycles after the request
      s_req[0] = 1; s_type[0] = 3'd4; s_addr[0] = 32'h8000_0014;
      tick();
      s_req[0] = 0;
      tick();
      chk("t1_arvalid", arvalid, 1'b1);
      chk("t1_araddr", araddr, 32'h8000_0010);
      chk("t1_arlen", arlen, 8'd1);
      chk("t1_arsize", arsize, 3'd3);
      s_arready = 1; tick(); s_arready = 0;
      s_rvalid = 1; s_rdata = 64'h1111; tick();
      s_rdata = 64'h2222; tick();
      s_rvalid = 0;
      chk("t1_rdy_back", ic_rd_rdy, 1'b1);

      // simultaneous requests, then three more ties: DC,IC repeated
      grants.delete();
      for (int k = 0; k < 4; k++) begin
         s_req[0] = 1; s_type[0] = 3'd4; s_addr[0] = 32'h8000_0100 + 32'(k * 16);
         s_req[1] = 1; s_type[1] = 3'd2; s_addr[1] = 32'hA000_0004;
         tick();
         s_req[0] = 0; s_req[1] = 0;
         drain("tie_drain_timeout");
      end
      chk("tie_count", grants.size(), 8);
      for (int k = 0; k < grants.size() && k < 8; k++)
         chk("tie_order", grants[k], (k % 2 == 0) ? 1 : 0);

      // address phase stalled: fields held, single handshake
      grants.delete();
      s_req[1] = 1; s_type[1] = 3'd1; s_addr[1] = 32'h1234_5676;
      tick(); s_req[1] = 0; tick();
      repeat (5) tick();
      drain("stall_drain_timeout");
      chk("stall_grants", grants.size(), 1);

      // error response on first line beat
      s_req[0] = 1; s_type[0] = 3'd4; s_addr[0] = 32'h8000_0040;
      tick(); s_req[0] = 0; tick();
      s_arready = 1; tick(); s_arready = 0;
      s_rvalid = 1; s_rdata = 64'hDEAD; s_rresp = 2'b10; tick();
      s_rresp = 2'b00; s_rdata = 64'hBEEF; tick();
      s_rvalid = 0; tick();
      chk("err_rdy_back", ic_rd_rdy, 1'b1);

      // asynchronous reset during the data phase
      s_req[0] = 1; s_type[0] = 3'd4; s_addr[0] = 32'h8000_0080;
      s_req[1] = 1; s_type[1] = 3'd3; s_addr[1] = 32'hA000_0008;
      tick(); s_req[0] = 0; s_req[1] = 0; tick();
      s_arready = 1; tick(); s_arready = 0;
      chk("pre_rst_rready", rready, 1'b1);
      rvalid = 1; rdata = 64'h5555; rlast = 0;
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_arvalid", arvalid, 1'b0);
      chk("mid_rst_rready", rready, 1'b0);
      chk("mid_rst_ret", {ic_ret_valid, dc_ret_valid}, 2'b00);
      chk("mid_rst_rdy", {ic_rd_rdy, dc_rd_rdy}, 2'b11);
      @(negedge clk);
      do_reset();
      s_req[0] = 1; s_type[0] = 3'd2; s_addr[0] = 32'h8000_1000;
      tick(); s_req[0] = 0;
      drain("post_rst_timeout");

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < 2; s++) begin
            s_req[s]  = ($urandom_range(0, 3) == 0);
            s_type[s] = 3'($urandom_range(0, 7));
            s_addr[s] = $urandom;
         end
         s_arready = ($urandom_range(0, 2) == 0);
         s_rvalid  = ($urandom_range(0, 1) == 1);
         s_rdata   = {$urandom, $urandom};
         s_rresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         tick();
      end
      drain("rand_drain_timeout");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
